// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
// Shared definitions for the instruction/data memory port arbiter:
//   - access width codes carried on d_width
//   - default null-pointer guard limit
//   - owner encoding and the registered response tag
package mem_bus_pkg;

   localparam logic [1:0]  WIDTH_BYTE = 2'd0;
   localparam logic [1:0]  WIDTH_HALF = 2'd1;
   localparam logic [1:0]  WIDTH_WORD = 2'd2;

   localparam logic [31:0] NULL_LIMIT_DEFAULT = 32'h0000_0100;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   // Everything needed one cycle after the grant to route and shape the
   // memory read data back to the right requester.
   typedef struct packed {
      owner_e     owner;
      logic [1:0] tail;
      logic [1:0] width;
      logic       we;
      logic       error;
   } rsp_tag_t;

endpackage

// File: rtl/mem_lane_steer.sv
// mem_lane_steer
// Purely combinational byte-lane steering for a 32-bit word memory.
// Write side: aligns right-justified write data onto its byte lanes and
// builds the byte write mask. Read side: shifts the addressed lanes down
// and zero-extends to the access width.
// Ports:
//   wr_width, wr_tail, wr_data  -> write request width code, addr[1:0], data
//   wr_mask, wr_lane_data       <- byte enables and lane-aligned write data
//   rd_width, rd_tail, rd_data  -> width code, addr[1:0] and raw memory word
//   rd_aligned                  <- right-aligned, zero-extended read data
module mem_lane_steer
   import mem_bus_pkg::*;
(
   input  logic [1:0]  wr_width,
   input  logic [1:0]  wr_tail,
   input  logic [31:0] wr_data,
   output logic [3:0]  wr_mask,
   output logic [31:0] wr_lane_data,
   input  logic [1:0]  rd_width,
   input  logic [1:0]  rd_tail,
   input  logic [31:0] rd_data,
   output logic [31:0] rd_aligned
);

   logic [31:0] rd_shifted;

   always_comb begin
      wr_lane_data = wr_data << {wr_tail, 3'b000};
      case (wr_width)
         WIDTH_BYTE: wr_mask = 4'b0001 << wr_tail;
         WIDTH_HALF: wr_mask = 4'b0011 << wr_tail;
         WIDTH_WORD: wr_mask = 4'b1111;
         default:    wr_mask = 4'b0000;
      endcase
   end

   always_comb begin
      rd_shifted = rd_data >> {rd_tail, 3'b000};
      case (rd_width)
         WIDTH_BYTE: rd_aligned = {24'h0, rd_shifted[7:0]};
         WIDTH_HALF: rd_aligned = {16'h0, rd_shifted[15:0]};
         WIDTH_WORD: rd_aligned = rd_shifted;
         default:    rd_aligned = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between an
// instruction-fetch port and a data port. Data has priority; a streak
// counter forces a fetch grant after MAX_DATA_STREAK consecutive data
// grants while a fetch is waiting. Every accepted access returns exactly
// one cycle later, including rejected ones.
// Ports:
//   clock, reset (async, active low)
//   i_req/i_addr -> i_ready (comb grant), i_valid/i_rdata (response)
//   d_req/d_we/d_width/d_addr/d_wdata -> d_ready (comb grant),
//                                        d_valid/d_rdata/d_error (response)
//   mem_en/mem_we/mem_addr/mem_wmask/mem_wdata -> RAM, mem_rdata <- RAM
module mem_port_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned MEM_WORDS       = 16384,
   parameter logic [31:0] NULL_LIMIT      = NULL_LIMIT_DEFAULT,
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         i_req,
   input  logic [31:0]                  i_addr,
   output logic                         i_ready,
   output logic                         i_valid,
   output logic [31:0]                  i_rdata,
   input  logic                         d_req,
   input  logic                         d_we,
   input  logic [1:0]                   d_width,
   input  logic [31:0]                  d_addr,
   input  logic [31:0]                  d_wdata,
   output logic                         d_ready,
   output logic                         d_valid,
   output logic [31:0]                  d_rdata,
   output logic                         d_error,
   output logic                         mem_en,
   output logic                         mem_we,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   output logic [3:0]                   mem_wmask,
   output logic [31:0]                  mem_wdata,
   input  logic [31:0]                  mem_rdata
);

   localparam int          AW         = $clog2(MEM_WORDS);
   localparam int          SW         = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
   // One bit wider than the address so MEM_WORDS*4 == 2^32 still compares.
   localparam logic [32:0] MEM_BYTES  = 33'(MEM_WORDS) << 2;

   logic          grant_i;
   logic          grant_d;
   logic [SW-1:0] streak;

   logic          i_oor;
   logic          d_oor;
   logic          d_null;
   logic          d_bad_width;
   logic          d_misalign;
   logic          d_err;
   logic [1:0]    d_tail;

   logic          rsp_valid;
   rsp_tag_t      rsp_tag;
   rsp_tag_t      tag_next;

   logic [3:0]    steer_wmask;
   logic [31:0]   steer_wdata;
   logic [31:0]   steer_rdata;

   // Arbitration: data first unless fetch has waited a full streak.
   always_comb begin
      grant_i = i_req && (!d_req || (streak == STREAK_MAX));
      grant_d = d_req && !grant_i;
   end

   assign i_ready = grant_i;
   assign d_ready = grant_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         streak <= '0;
      end else if (grant_i || !i_req) begin
         streak <= '0;
      end else if (grant_d && (streak != STREAK_MAX)) begin
         streak <= streak + 1'b1;
      end
   end

   // Request checks
   always_comb begin
      d_tail      = d_addr[1:0];
      i_oor       = ({1'b0, i_addr} >= MEM_BYTES);
      d_oor       = ({1'b0, d_addr} >= MEM_BYTES);
      d_null      = (d_addr < NULL_LIMIT);
      d_bad_width = (d_width == 2'd3);
      d_misalign  = ((d_width == WIDTH_HALF) && (d_tail == 2'd3)) ||
                    ((d_width == WIDTH_WORD) && (d_tail != 2'd0));
      d_err       = d_oor || d_null || d_bad_width || d_misalign;
   end

   mem_lane_steer u_lane_steer (
      .wr_width     (d_width),
      .wr_tail      (d_tail),
      .wr_data      (d_wdata),
      .wr_mask      (steer_wmask),
      .wr_lane_data (steer_wdata),
      .rd_width     (rsp_tag.width),
      .rd_tail      (rsp_tag.tail),
      .rd_data      (mem_rdata),
      .rd_aligned   (steer_rdata)
   );

   // Memory issue. Rejected accesses never touch the RAM.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = d_addr[2 +: AW];
      mem_wmask = 4'b0000;
      mem_wdata = 32'h0;
      if (grant_i) begin
         mem_en   = !i_oor;
         mem_addr = i_addr[2 +: AW];
      end else if (grant_d) begin
         mem_en = !d_err;
         mem_we = d_we && !d_err;
         if (d_we && !d_err) begin
            mem_wmask = steer_wmask;
            mem_wdata = steer_wdata;
         end
      end
   end

   // Response tag captured at grant; fetches are always whole words.
   always_comb begin
      tag_next.owner = grant_i ? OWNER_I : OWNER_D;
      tag_next.tail  = grant_i ? 2'd0 : d_tail;
      tag_next.width = grant_i ? WIDTH_WORD : d_width;
      tag_next.we    = grant_d && d_we;
      tag_next.error = grant_i ? i_oor : d_err;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_tag   <= '0;
      end else begin
         rsp_valid <= grant_i || grant_d;
         rsp_tag   <= tag_next;
      end
   end

   // Responses. Rejected fetches and all writes return zero data.
   always_comb begin
      i_valid = rsp_valid && (rsp_tag.owner == OWNER_I);
      d_valid = rsp_valid && (rsp_tag.owner == OWNER_D);
      d_error = d_valid && rsp_tag.error;
      i_rdata = (i_valid && !rsp_tag.error) ? mem_rdata : 32'h0;
      d_rdata = (d_valid && !rsp_tag.error && !rsp_tag.we) ? steer_rdata : 32'h0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic        i_valid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_width;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        d_error;
   logic        mem_en;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:16383];

   int tests_run;
   int tests_failed;

   mem_port_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ready   (i_ready),
      .i_valid   (i_valid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_width   (d_width),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .d_error   (d_error),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single-port synchronous RAM, one cycle read latency.
   always @(posedge clock) begin
      if (mem_en) begin
         mem_rdata <= mem[mem_addr];
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b]) mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
         end
      end
   end

   task automatic idle_inputs();
      i_req   = 1'b0;
      i_addr  = 32'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_width = 2'd0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
   endtask

   task automatic drive_d(input logic we, input logic [1:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata);
      d_req   = 1'b1;
      d_we    = we;
      d_width = width;
      d_addr  = addr;
      d_wdata = wdata;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clock);
      tests_run++; if (i_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_i_valid: got %b want 0", i_valid); end
      tests_run++; if (d_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_d_valid: got %b want 0", d_valid); end
      tests_run++; if (d_error !== 1'b0) begin tests_failed++; $display("FAIL reset_d_error: got %b want 0", d_error); end
      tests_run++; if (i_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata); end
      tests_run++; if (d_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
      tests_run++; if ({i_ready, d_ready, mem_en} !== 3'b000) begin tests_failed++; $display("FAIL reset_idle_grant: got %b want 000", {i_ready, d_ready, mem_en}); end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_fetch();
      mem[14'h080] = 32'h1234_5678;
      i_req  = 1'b1;
      i_addr = 32'h200;
      #1;
      tests_run++; if (i_ready !== 1'b1) begin tests_failed++; $display("FAIL fetch_ready: got %b want 1", i_ready); end
      tests_run++; if (d_ready !== 1'b0) begin tests_failed++; $display("FAIL fetch_d_ready: got %b want 0", d_ready); end
      tests_run++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL fetch_mem_en: got en=%b we=%b want 1 0", mem_en, mem_we); end
      tests_run++; if (mem_addr !== 14'h080) begin tests_failed++; $display("FAIL fetch_mem_addr: got %h want 080", mem_addr); end
      @(negedge clock);
      tests_run++; if (i_valid !== 1'b1) begin tests_failed++; $display("FAIL fetch_valid: got %b want 1", i_valid); end
      tests_run++; if (i_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL fetch_rdata: got %h want 12345678", i_rdata); end
      tests_run++; if (d_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_no_d_valid: got %b want 0", d_valid); end
      // out-of-range fetch: granted, no RAM access, zero data
      i_addr = 32'h0001_0000;
      #1;
      tests_run++; if (i_ready !== 1'b1 || mem_en !== 1'b0) begin tests_failed++; $display("FAIL fetch_oor_issue: got ready=%b en=%b want 1 0", i_ready, mem_en); end
      @(negedge clock);
      i_req = 1'b0;
      tests_run++; if (i_valid !== 1'b1 || i_rdata !== 32'h0) begin tests_failed++; $display("FAIL fetch_oor_rsp: got valid=%b rdata=%h want 1 0", i_valid, i_rdata); end
      @(negedge clock);
      tests_run++; if (i_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_pulse: got %b want 0", i_valid); end
   endtask

   task automatic test_lanes();
      mem[14'h0C0] = 32'h0;
      drive_d(1'b1, 2'd0, 32'h301, 32'h0000_00AB);
      #1;
      tests_run++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin tests_failed++; $display("FAIL wr_byte_ready: got d=%b i=%b want 1 0", d_ready, i_ready); end
      tests_run++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin tests_failed++; $display("FAIL wr_byte_en: got en=%b we=%b want 1 1", mem_en, mem_we); end
      tests_run++; if (mem_wmask !== 4'b0010) begin tests_failed++; $display("FAIL wr_byte_mask: got %b want 0010", mem_wmask); end
      tests_run++; if (mem_wdata !== 32'h0000_AB00) begin tests_failed++; $display("FAIL wr_byte_wdata: got %h want 0000ab00", mem_wdata); end
      tests_run++; if (mem_addr !== 14'h0C0) begin tests_failed++; $display("FAIL wr_byte_addr: got %h want 0c0", mem_addr); end
      @(negedge clock);
      tests_run++; if (d_valid !== 1'b1 || d_error !== 1'b0 || d_rdata !== 32'h0) begin tests_failed++; $display("FAIL wr_byte_rsp: got v=%b e=%b r=%h want 1 0 0", d_valid, d_error, d_rdata); end
      tests_run++; if (mem[14'h0C0] !== 32'h0000_AB00) begin tests_failed++; $display("FAIL wr_byte_ram: got %h want 0000ab00", mem[14'h0C0]); end
      mem[14'h0C0] = 32'hDEAD_BEEF;
      drive_d(1'b0, 2'd1, 32'h302, 32'h0);
      @(negedge clock);
      drive_d(1'b0, 2'd0, 32'h301, 32'h0);
      tests_run++; if (d_valid !== 1'b1 || d_rdata !== 32'h0000_DEAD) begin tests_failed++; $display("FAIL rd_half: got v=%b r=%h want 1 0000dead", d_valid, d_rdata); end
      @(negedge clock);
      drive_d(1'b0, 2'd2, 32'h300, 32'h0);
      tests_run++; if (d_rdata !== 32'h0000_00BE) begin tests_failed++; $display("FAIL rd_byte: got %h want 000000be", d_rdata); end
      @(negedge clock);
      drive_d(1'b1, 2'd1, 32'h302, 32'hFFFF_1234);
      tests_run++; if (d_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_word: got %h want deadbeef", d_rdata); end
      #1;
      tests_run++; if (mem_wmask !== 4'b1100 || mem_wdata !== 32'h1234_0000) begin tests_failed++; $display("FAIL wr_half_lanes: got mask=%b data=%h want 1100 12340000", mem_wmask, mem_wdata); end
      @(negedge clock);
      idle_inputs();
      tests_run++; if (mem[14'h0C0] !== 32'h1234_BEEF) begin tests_failed++; $display("FAIL wr_half_ram: got %h want 1234beef", mem[14'h0C0]); end
      @(negedge clock);
   endtask

   task automatic test_errors();
      mem[14'h0]    = 32'h5A5A_5A5A;
      mem[14'h3FFF] = 32'hC0FF_EE11;
      drive_d(1'b0, 2'd2, 32'h40, 32'h0);
      #1;
      tests_run++; if (d_ready !== 1'b1 || mem_en !== 1'b0) begin tests_failed++; $display("FAIL err_null_issue: got ready=%b en=%b want 1 0", d_ready, mem_en); end
      @(negedge clock);
      tests_run++; if (d_valid !== 1'b1 || d_error !== 1'b1 || d_rdata !== 32'h0) begin tests_failed++; $display("FAIL err_null_rsp: got v=%b e=%b r=%h want 1 1 0", d_valid, d_error, d_rdata); end
      drive_d(1'b0, 2'd2, 32'h202, 32'h0);
      #1;
      tests_run++; if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL err_word_misalign_en: got %b want 0", mem_en); end
      @(negedge clock);
      tests_run++; if (d_error !== 1'b1) begin tests_failed++; $display("FAIL err_word_misalign: got %b want 1", d_error); end
      drive_d(1'b1, 2'd2, 32'h0001_0000, 32'hFFFF_FFFF);
      #1;
      tests_run++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL err_oor_wr_en: got en=%b we=%b want 0 0", mem_en, mem_we); end
      @(negedge clock);
      tests_run++; if (d_valid !== 1'b1 || d_error !== 1'b1) begin tests_failed++; $display("FAIL err_oor_wr_rsp: got v=%b e=%b want 1 1", d_valid, d_error); end
      tests_run++; if (mem[14'h0] !== 32'h5A5A_5A5A) begin tests_failed++; $display("FAIL err_oor_wr_ram: got %h want 5a5a5a5a", mem[14'h0]); end
      drive_d(1'b0, 2'd3, 32'h300, 32'h0);
      @(negedge clock);
      tests_run++; if (d_error !== 1'b1) begin tests_failed++; $display("FAIL err_width3: got %b want 1", d_error); end
      drive_d(1'b0, 2'd1, 32'h303, 32'h0);
      @(negedge clock);
      tests_run++; if (d_error !== 1'b1) begin tests_failed++; $display("FAIL err_half_tail3: got %b want 1", d_error); end
      drive_d(1'b0, 2'd0, 32'hFF, 32'h0);
      @(negedge clock);
      tests_run++; if (d_error !== 1'b1) begin tests_failed++; $display("FAIL err_null_edge: got %b want 1", d_error); end
      drive_d(1'b0, 2'd0, 32'hFFFF, 32'h0);
      #1;
      tests_run++; if (mem_en !== 1'b1 || mem_addr !== 14'h3FFF) begin tests_failed++; $display("FAIL top_byte_issue: got en=%b addr=%h want 1 3fff", mem_en, mem_addr); end
      @(negedge clock);
      idle_inputs();
      tests_run++; if (d_error !== 1'b0 || d_rdata !== 32'h0000_00C0) begin tests_failed++; $display("FAIL top_byte_rsp: got e=%b r=%h want 0 000000c0", d_error, d_rdata); end
      @(negedge clock);
   endtask

   task automatic test_starvation();
      logic [9:0] exp_i;
      exp_i = 10'b10_0001_0000;
      i_req  = 1'b1;
      i_addr = 32'h200;
      drive_d(1'b0, 2'd2, 32'h100, 32'h0);
      for (int c = 0; c < 10; c++) begin
         #1;
         tests_run++;
         if (i_ready !== exp_i[c] || d_ready !== !exp_i[c]) begin
            tests_failed++;
            $display("FAIL starve_grant_%0d: got i=%b d=%b want i=%b d=%b", c, i_ready, d_ready, exp_i[c], !exp_i[c]);
         end
         @(negedge clock);
      end
      idle_inputs();
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_data [3];
      exp_data[0] = 32'hA0A0_0001;
      exp_data[1] = 32'hB0B0_0002;
      exp_data[2] = 32'hC0C0_0003;
      mem[14'h040] = exp_data[0];
      mem[14'h041] = exp_data[1];
      mem[14'h042] = exp_data[2];
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            tests_run++;
            if (d_valid !== 1'b1 || d_rdata !== exp_data[k-1]) begin
               tests_failed++;
               $display("FAIL b2b_rd_%0d: got v=%b r=%h want 1 %h", k-1, d_valid, d_rdata, exp_data[k-1]);
            end
         end
         if (k < 3) drive_d(1'b0, 2'd2, 32'h100 + 32'(k*4), 32'h0);
         else       idle_inputs();
         @(negedge clock);
      end
      tests_run++; if (d_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got %b want 0", d_valid); end
   endtask

   task automatic test_reset_mid();
      logic [4:0] exp_i;
      exp_i = 5'b10000;
      // fetch in flight when reset drops
      i_req  = 1'b1;
      i_addr = 32'h200;
      @(posedge clock);
      #1;
      i_req = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      tests_run++; if (i_valid !== 1'b0 || i_rdata !== 32'h0) begin tests_failed++; $display("FAIL rstmid_fetch_drop: got v=%b r=%h want 0 0", i_valid, i_rdata); end
      reset = 1'b1;
      @(negedge clock);
      tests_run++; if (i_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_retry: got %b want 0", i_valid); end
      // build a data streak, then reset it away
      i_req  = 1'b1;
      i_addr = 32'h200;
      drive_d(1'b0, 2'd2, 32'h100, 32'h0);
      @(negedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      tests_run++; if (d_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_d_drop: got %b want 0", d_valid); end
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         tests_run++;
         if (i_ready !== exp_i[c] || d_ready !== !exp_i[c]) begin
            tests_failed++;
            $display("FAIL rstmid_streak_%0d: got i=%b d=%b want i=%b d=%b", c, i_ready, d_ready, exp_i[c], !exp_i[c]);
         end
         @(negedge clock);
      end
      idle_inputs();
      @(negedge clock);
      i_req  = 1'b1;
      i_addr = 32'h200;
      @(negedge clock);
      i_req = 1'b0;
      tests_run++; if (i_valid !== 1'b1 || i_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL rstmid_after: got v=%b r=%h want 1 12345678", i_valid, i_rdata); end
      @(negedge clock);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      for (int k = 0; k < 16384; k++) mem[k] = 32'h0;
      mem_rdata = 32'h0;
      test_reset();
      test_fetch();
      test_lanes();
      test_errors();
      test_starvation();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no summary want summary");
      $fatal(1);
   end

endmodule
